sp_usb_fifo_dev: RTL and testbench

- Device-side counterpart of the synchronous USB FIFO interface used by `sp_usb_sync`. It emulates the FT245-style sync FIFO chip in an FPGA-only build or bench.
- It holds two queues:
  - RX (PC→FPGA): presented to the host logic via `rxf_n`/`usb_data`.
  - TX (FPGA→PC): filled by host-logic writes, gated by `txe_n`.
- A simple PC-side port feeds RX and drains TX.
- It sits between `sp_usb_sync` (FPGA side) and a stimulus source or PC-side bridge.

---
 rtl/sp_usb_fifo_dev.sv | 105 ++++++++++
 tb/tb_sp_usb_fifo_dev.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_usb_fifo_dev.sv
// sp_usb_fifo_dev: FT245-style sync FIFO device with RX (PC->host) and TX (host->PC) queues.
// Optional SP_USB_FIFO_DEV_LOOPBACK_EN routes accepted host writes back into RX instead of pc_write.
module sp_usb_fifo_dev #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] usb_data,
    output logic             rxf_n,
    output logic             txe_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [WIDTH-1:0] pc_din,
    input  logic             pc_write,
    output logic             pc_full,
    output logic [WIDTH-1:0] pc_dout,
    input  logic             pc_read,
    output logic             pc_avail,
    output logic             overflow
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      rx_mem [DEPTH];
    logic [WIDTH-1:0]      tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
    logic [DEPTH_LOG2:0]   rx_count, tx_count;
    logic [WIDTH-1:0]      bus_q;
    logic                  overflow_q;

    logic                  rx_pop, rx_push_req, rx_push, rx_drop;
    logic                  tx_pop, tx_push_req, tx_push, tx_drop;
    logic [WIDTH-1:0]      rx_push_data;
    logic [WIDTH-1:0]      bus_drive;

`ifdef SP_USB_FIFO_DEV_LOOPBACK_EN
    logic unused_pc_side;
    assign unused_pc_side = ^{pc_din, pc_write};
`endif

    // A same-edge pop frees a slot first, so a push at full is still accepted.
    always_comb begin
        tx_push_req  = ~wr_n;
        tx_pop       = pc_read && (tx_count != '0);
        tx_push      = tx_push_req && ((tx_count != FULL) || tx_pop);
        tx_drop      = tx_push_req && !tx_push;
`ifdef SP_USB_FIFO_DEV_LOOPBACK_EN
        rx_push_req  = tx_push;
        rx_push_data = bus_q;
`else
        rx_push_req  = pc_write;
        rx_push_data = pc_din;
`endif
        rx_pop       = ~rd_n && (rx_count != '0);
        rx_push      = rx_push_req && ((rx_count != FULL) || rx_pop);
        rx_drop      = rx_push_req && !rx_push;
        bus_drive    = (rx_count == '0) ? '0 : rx_mem[rx_rd];
    end

    assign usb_data = rd_n ? {WIDTH{1'bz}} : bus_drive;

    assign rxf_n    = (rx_count == '0);
    assign txe_n    = (tx_count == FULL);
    assign pc_full  = (rx_count == FULL);
    assign pc_avail = (tx_count != '0);
    assign pc_dout  = tx_mem[tx_rd];
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rx_push && !rst) rx_mem[rx_wr] <= rx_push_data;
        if (tx_push && !rst) tx_mem[tx_wr] <= bus_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rd      <= '0;
            rx_wr      <= '0;
            tx_rd      <= '0;
            tx_wr      <= '0;
            rx_count   <= '0;
            tx_count   <= '0;
            bus_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // The host drives data one cycle before wr_n, so the bus is captured every cycle.
            bus_q      <= usb_data;
            overflow_q <= overflow_q | rx_drop | tx_drop;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_usb_fifo_dev.sv
// Self-checking bench for sp_usb_fifo_dev: directed scenarios plus randomized traffic vs a queue model.
module tb_sp_usb_fifo_dev;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] pc_din = 8'h00;
    logic       pc_write = 1'b0, pc_read = 1'b0;
    logic       host_oe = 1'b0;
    logic [7:0] host_drv = 8'h00;
    wire  [7:0] usb_data;
    logic       rxf_n, txe_n, pc_full, pc_avail, overflow;
    logic [7:0] pc_dout;

    int vectors = 0;
    int miscompares = 0;

    assign usb_data = host_oe ? host_drv : 8'bz;

    sp_usb_fifo_dev #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .usb_data(usb_data), .rxf_n(rxf_n), .txe_n(txe_n),
        .rd_n(rd_n), .wr_n(wr_n), .pc_din(pc_din), .pc_write(pc_write),
        .pc_full(pc_full), .pc_dout(pc_dout), .pc_read(pc_read),
        .pc_avail(pc_avail), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: two byte queues, a sticky error bit, and the byte the host drove last edge.
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_bus = 8'h00;
    logic [7:0] m_tmp;
    logic       m_tx_acc;

    always @(posedge clk) begin
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            m_ovf = 1'b0;
            m_bus = 8'h00;
        end else begin
            if (!rd_n && rx_q.size() > 0) m_tmp = rx_q.pop_front();
            if (pc_read && tx_q.size() > 0) m_tmp = tx_q.pop_front();
            m_tx_acc = 1'b0;
            if (!wr_n) begin
                if (tx_q.size() < DEPTH) begin
                    tx_q.push_back(m_bus);
                    m_tx_acc = 1'b1;
                end else m_ovf = 1'b1;
            end
`ifdef SP_USB_FIFO_DEV_LOOPBACK_EN
            if (m_tx_acc) begin
                if (rx_q.size() < DEPTH) rx_q.push_back(m_bus);
                else m_ovf = 1'b1;
            end
`else
            if (pc_write) begin
                if (rx_q.size() < DEPTH) rx_q.push_back(pc_din);
                else m_ovf = 1'b1;
            end
`endif
            m_bus = host_oe ? host_drv : 8'h00;
        end
    end

    task automatic cyc(input logic rd, input logic wr, input logic pw, input logic [7:0] din,
                       input logic pr, input logic oe, input logic [7:0] hd);
        rd_n     = ~rd;
        wr_n     = ~wr;
        pc_write = pw;
        pc_din   = din;
        pc_read  = pr;
        host_oe  = oe & ~rd;
        host_drv = hd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 8'h00, 0, 1, 8'h96);
        tick();
        tick();
        rst = 1'b0;
        cyc(0, 0, 0, 8'h00, 0, 1, 8'h96);
        vectors++;
        if ({rxf_n, txe_n, pc_full, pc_avail, overflow} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_status got %b want %b", {rxf_n, txe_n, pc_full, pc_avail, overflow}, 5'b10000);
        end
        vectors++;
        if (usb_data !== 8'h96) begin
            miscompares++;
            $display("FAIL reset_bus_released got %h want %h", usb_data, 8'h96);
        end
        tick();
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (usb_data !== 8'h00) begin
            miscompares++;
            $display("FAIL empty_read_bus got %h want %h", usb_data, 8'h00);
        end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if ({rxf_n, pc_avail, overflow} !== 3'b100) begin
            miscompares++;
            $display("FAIL empty_read_status got %b want %b", {rxf_n, pc_avail, overflow}, 3'b100);
        end
    endtask

`ifndef SP_USB_FIFO_DEV_LOOPBACK_EN
    task automatic test_pc_to_host();
        do_reset();
        cyc(0, 0, 1, 8'hA5, 0, 0, 8'h00);
        vectors++;
        if (rxf_n !== 1'b1) begin miscompares++; $display("FAIL p2h_rxf_before got %b want 1", rxf_n); end
        tick();
        cyc(0, 0, 1, 8'h3C, 0, 0, 8'h00);
        vectors++;
        if (rxf_n !== 1'b0) begin miscompares++; $display("FAIL p2h_rxf_latency got %b want 0", rxf_n); end
        tick();
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (usb_data !== 8'hA5) begin miscompares++; $display("FAIL p2h_first got %h want a5", usb_data); end
        tick();
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (usb_data !== 8'h3C) begin miscompares++; $display("FAIL p2h_second got %h want 3c", usb_data); end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (rxf_n !== 1'b1) begin miscompares++; $display("FAIL p2h_rxf_after got %b want 1", rxf_n); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 8'(8'h80 + i), 0, 0, 8'h00);
            tick();
        end
        cyc(1, 0, 1, 8'hC7, 0, 0, 8'h00);
        vectors++;
        if (pc_full !== 1'b1 || usb_data !== 8'h80) begin
            miscompares++;
            $display("FAIL simul_pre got full=%b bus=%h want full=1 bus=80", pc_full, usb_data);
        end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if ({pc_full, overflow} !== 2'b10) begin
            miscompares++;
            $display("FAIL simul_post got full,ovf=%b want 10", {pc_full, overflow});
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] want;
            want = (i < DEPTH - 1) ? 8'(8'h81 + i) : 8'hC7;
            cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
            vectors++;
            if (usb_data !== want) begin
                miscompares++;
                $display("FAIL simul_drain[%0d] got %h want %h", i, usb_data, want);
            end
            tick();
        end
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (rxf_n !== 1'b1) begin miscompares++; $display("FAIL simul_empty got %b want 1", rxf_n); end
    endtask
`else
    task automatic test_loopback();
        do_reset();
        cyc(0, 0, 1, 8'h77, 0, 1, 8'h11);
        tick();
        cyc(0, 1, 0, 8'h00, 0, 1, 8'h22);
        vectors++;
        if (rxf_n !== 1'b1) begin miscompares++; $display("FAIL lb_pc_write_ignored got %b want 1", rxf_n); end
        tick();
        cyc(0, 1, 0, 8'h00, 0, 1, 8'h00);
        vectors++;
        if (rxf_n !== 1'b0) begin miscompares++; $display("FAIL lb_rxf got %b want 0", rxf_n); end
        tick();
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (usb_data !== 8'h11) begin miscompares++; $display("FAIL lb_first got %h want 11", usb_data); end
        tick();
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (usb_data !== 8'h22) begin miscompares++; $display("FAIL lb_second got %h want 22", usb_data); end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if ({rxf_n, pc_avail} !== 2'b11) begin
            miscompares++;
            $display("FAIL lb_after got rxf,avail=%b want 11", {rxf_n, pc_avail});
        end
    endtask
`endif

    task automatic test_host_write();
        do_reset();
        cyc(0, 0, 0, 8'h00, 0, 1, 8'h5A);
        tick();
        cyc(0, 1, 0, 8'h00, 0, 1, 8'hFF);
        vectors++;
        if (pc_avail !== 1'b0) begin miscompares++; $display("FAIL hw_avail_early got %b want 0", pc_avail); end
        tick();
        cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
        vectors++;
        if (pc_avail !== 1'b1 || pc_dout !== 8'h5A) begin
            miscompares++;
            $display("FAIL hw_data got avail=%b dout=%h want avail=1 dout=5a", pc_avail, pc_dout);
        end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (pc_avail !== 1'b0) begin miscompares++; $display("FAIL hw_read_clears got %b want 0", pc_avail); end
    endtask

    task automatic test_tx_full();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(0, (i > 0), 0, 8'h00, 0, 1, 8'(8'h40 + i));
            tick();
        end
        cyc(0, 1, 0, 8'h00, 0, 1, 8'hEE);
        vectors++;
        if ({txe_n, overflow} !== 2'b10) begin
            miscompares++;
            $display("FAIL txfull_pre got txe,ovf=%b want 10", {txe_n, overflow});
        end
        tick();
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if ({txe_n, overflow} !== 2'b11) begin
            miscompares++;
            $display("FAIL txfull_overflow got txe,ovf=%b want 11", {txe_n, overflow});
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
            vectors++;
            if (pc_dout !== 8'(8'h40 + i)) begin
                miscompares++;
                $display("FAIL txfull_drain[%0d] got %h want %h", i, pc_dout, 8'(8'h40 + i));
            end
            tick();
        end
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if ({pc_avail, overflow} !== 2'b01) begin
            miscompares++;
            $display("FAIL txfull_sticky got avail,ovf=%b want 01", {pc_avail, overflow});
        end
    endtask

    task automatic test_random();
        logic prev_oe;
        logic rd, wr, pw, pr, oe, fill;
        logic [4:0] exp_st;
        do_reset();
        prev_oe = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            fill = ((i / 150) % 2) == 0;
            rd   = fill ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            oe   = !rd;
            wr   = prev_oe && (fill ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2));
            pw   = fill ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            pr   = fill ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            cyc(rd, wr, pw, 8'($urandom), pr, oe, 8'($urandom));
            exp_st = {(rx_q.size() == 0), (tx_q.size() == DEPTH), (rx_q.size() == DEPTH),
                      (tx_q.size() != 0), m_ovf};
            vectors++;
            if ({rxf_n, txe_n, pc_full, pc_avail, overflow} !== exp_st) begin
                miscompares++;
                $display("FAIL rand_status[%0d] got %b want %b", i, {rxf_n, txe_n, pc_full, pc_avail, overflow}, exp_st);
            end
            if (tx_q.size() != 0) begin
                vectors++;
                if (pc_dout !== tx_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_pc_dout[%0d] got %h want %h", i, pc_dout, tx_q[0]);
                end
            end
            if (rd) begin
                vectors++;
                if (usb_data !== ((rx_q.size() != 0) ? rx_q[0] : 8'h00)) begin
                    miscompares++;
                    $display("FAIL rand_usb_data[%0d] got %h want %h", i, usb_data,
                             (rx_q.size() != 0) ? rx_q[0] : 8'h00);
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                prev_oe = 1'b0;
            end else begin
                tick();
                prev_oe = oe;
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef SP_USB_FIFO_DEV_LOOPBACK_EN
        test_pc_to_host();
        test_full_simul();
`else
        test_loopback();
`endif
        test_host_write();
        test_tx_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
